// File: rtl/switch_arbiter_if.sv
// Request / gate-enable bundle shared by the requesters, the arbiter and the
// switch-level gate instances. The arbiter drives the gates (master); the
// requester/gate side uses the slave view.
interface switch_arbiter_if #(
    parameter int N = 4
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  sw_en;
    logic [N-1:0]  sw_en_n;
    logic [OW-1:0] owner;
    logic          busy;

    modport master (
        input  req,
        output sw_en,
        output sw_en_n,
        output owner,
        output busy
    );

    modport slave (
        output req,
        input  sw_en,
        input  sw_en_n,
        input  owner,
        input  busy
    );
endinterface

// File: rtl/switch_arbiter.sv
// Break-before-make arbiter for a shared transmission-gate node.
// Grants one requester at a time (round-robin), keeps every gate open for
// DEAD_CYCLES between owners, holds a grant for at least MIN_HOLD cycles and
// optionally forces a release after MAX_HOLD cycles when others are waiting.
// All outputs come straight from flops; nothing combinational reaches the gates.
module switch_arbiter #(
    parameter int N           = 4,
    parameter int DEAD_CYCLES = 2,
    parameter int MIN_HOLD    = 4,
    parameter int MAX_HOLD    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    switch_arbiter_if.master  bus
);
    localparam int OW       = (N > 1) ? $clog2(N) : 1;
    localparam int HOLD_SAT = (MAX_HOLD > MIN_HOLD) ? MAX_HOLD : MIN_HOLD;
    localparam int HW       = $clog2(HOLD_SAT + 1);
    localparam int DW       = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [HW-1:0] HOLD_SAT_C = HW'(HOLD_SAT);
    localparam logic [HW-1:0] MIN_M1_C   = HW'(MIN_HOLD - 1);
    localparam logic [HW-1:0] MAX_M1_C   = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [DW-1:0] DEAD_M1_C  = DW'(DEAD_CYCLES - 1);
    localparam logic          MAX_EN     = (MAX_HOLD != 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    // One-hot decode of a requester index.
    function automatic logic [N-1:0] onehot(input logic [OW-1:0] idx);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Index following idx, wrapping N-1 -> 0.
    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
        return OW'((int'(idx) + 1) % N);
    endfunction

    // First set request at or above the pointer, wrapping around.
    function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] p);
        logic [OW-1:0] win;
        logic          found;
        int            idx;
        win   = p;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(p) + i) % N;
            if (!found && r[idx]) begin
                win   = OW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    logic [1:0]    state_r,    state_s;
    logic [OW-1:0] owner_r,    owner_s;
    logic [OW-1:0] ptr_r,      ptr_s;
    logic [N-1:0]  sw_en_r,    sw_en_s;
    logic [N-1:0]  sw_en_n_r;
    logic          busy_r,     busy_s;
    logic [HW-1:0] hold_cnt_r, hold_s;
    logic [DW-1:0] dead_cnt_r, dead_s;

    logic          any_req_s;
    logic          own_req_s;
    logic          others_s;
    logic          release_s;
    logic [OW-1:0] win_s;

    assign any_req_s = |bus.req;
    assign own_req_s = |(bus.req & onehot(owner_r));
    assign others_s  = |(bus.req & ~onehot(owner_r));
    assign win_s     = rr_pick(bus.req, ptr_r);
    // Owner may leave once it has been on for MIN_HOLD cycles, or is evicted
    // on the MAX_HOLD-th cycle if someone else is waiting.
    assign release_s = (!own_req_s && (hold_cnt_r >= MIN_M1_C)) ||
                       (MAX_EN && (hold_cnt_r == MAX_M1_C) && others_s);

    // Next-state and next-output computation for the grant FSM.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        ptr_s   = ptr_r;
        sw_en_s = sw_en_r;
        hold_s  = hold_cnt_r;
        dead_s  = dead_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    owner_s = win_s;
                    sw_en_s = onehot(win_s);
                    hold_s  = '0;
                    state_s = ST_ON;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ON: begin
                if (hold_cnt_r < HOLD_SAT_C) begin
                    hold_s = hold_cnt_r + 1'b1;
                end else begin
                    hold_s = hold_cnt_r;
                end
                if (release_s) begin
                    sw_en_s = '0;
                    ptr_s   = next_idx(owner_r);
                    dead_s  = '0;
                    state_s = ST_DEAD;
                end else begin
                    state_s = ST_ON;
                end
            end
            ST_DEAD: begin
                if (dead_cnt_r == DEAD_M1_C) begin
                    if (any_req_s) begin
                        owner_s = win_s;
                        sw_en_s = onehot(win_s);
                        hold_s  = '0;
                        state_s = ST_ON;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    dead_s = dead_cnt_r + 1'b1;
                end
            end
            default: begin
                sw_en_s = '0;
                hold_s  = '0;
                dead_s  = '0;
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s == ST_ON) || (state_s == ST_DEAD);
    end

    // State, counters and registered gate enables; reset opens every gate at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            owner_r    <= '0;
            ptr_r      <= '0;
            sw_en_r    <= '0;
            sw_en_n_r  <= '1;
            busy_r     <= 1'b0;
            hold_cnt_r <= '0;
            dead_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            ptr_r      <= ptr_s;
            sw_en_r    <= sw_en_s;
            sw_en_n_r  <= ~sw_en_s;
            busy_r     <= busy_s;
            hold_cnt_r <= hold_s;
            dead_cnt_r <= dead_s;
        end
    end

    assign bus.sw_en   = sw_en_r;
    assign bus.sw_en_n = sw_en_n_r;
    assign bus.owner   = owner_r;
    assign bus.busy    = busy_r;
endmodule

// File: tb/tb_switch_arbiter.sv
// Bench for switch_arbiter: a per-grant behavioural model (on-time and gap
// lengths, round-robin pointer) checked every cycle, plus hand-computed
// grant-sequence expectations for the directed scenarios.
module tb_switch_arbiter;
    localparam int N    = 4;
    localparam int DEAD = 2;
    localparam int MINH = 4;
    localparam int MAXH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    switch_arbiter_if #(.N(N)) bus ();

    switch_arbiter #(
        .N(N), .DEAD_CYCLES(DEAD), .MIN_HOLD(MINH), .MAX_HOLD(MAXH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: current owner (-1 = none), cycles it has been on, dead cycles
    // elapsed, round-robin pointer, last granted index.
    int m_owner, m_on, m_gap, m_ptr, m_last;
    bit m_dead;

    // Observed gate runs and all-open gaps between them.
    logic [N-1:0] runs_val[$];
    int           runs_len[$];
    int           gaps[$];
    logic [N-1:0] cur_val;
    int           cur_len, zero_len;
    bit           seen_run;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_on = 0; m_gap = 0; m_ptr = 0; m_last = 0; m_dead = 1'b0;
    endtask

    task automatic model_grant(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (r[k]) begin
                m_owner = k; m_last = k; m_on = 1; m_dead = 1'b0;
                break;
            end
        end
    endtask

    task automatic model_step(input logic [N-1:0] r);
        bit others;
        others = 1'b0;
        if (m_owner >= 0) begin
            for (int j = 0; j < N; j++)
                if (j != m_owner && r[j]) others = 1'b1;
            if ((!r[m_owner] && m_on >= MINH) || (MAXH != 0 && m_on == MAXH && others)) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_dead = 1'b1; m_gap = 1;
            end else begin
                m_on++;
            end
        end else if (m_dead) begin
            if (m_gap == DEAD) begin
                m_dead = 1'b0;
                if (r != '0) model_grant(r);
            end else begin
                m_gap++;
            end
        end else if (r != '0) begin
            model_grant(r);
        end
    endtask

    task automatic compare();
        logic [N-1:0] e, en;
        logic         b;
        e  = '0;
        if (m_owner >= 0) e[m_owner] = 1'b1;
        en = ~e;
        b  = (m_owner >= 0) || m_dead;
        chk("sw_en", bus.sw_en, e);
        chk("sw_en_n", bus.sw_en_n, en);
        chk("busy", bus.busy, b);
        chk("onehot", ($countones(bus.sw_en) <= 1), 1);
        if (m_owner >= 0) chk("owner", bus.owner, m_last);
    endtask

    task automatic clear_log();
        runs_val.delete(); runs_len.delete(); gaps.delete();
        cur_val = '0; cur_len = 0; zero_len = 0; seen_run = 1'b0;
    endtask

    task automatic track();
        if (bus.sw_en != '0) begin
            if (cur_len > 0 && bus.sw_en == cur_val) begin
                cur_len++;
            end else begin
                if (cur_len > 0) begin runs_val.push_back(cur_val); runs_len.push_back(cur_len); end
                if (seen_run) gaps.push_back(zero_len);
                cur_val = bus.sw_en; cur_len = 1; zero_len = 0; seen_run = 1'b1;
            end
        end else begin
            if (cur_len > 0) begin runs_val.push_back(cur_val); runs_len.push_back(cur_len); cur_len = 0; end
            zero_len++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(bus.req);
        #1;
        compare();
        track();
    endtask

    task automatic run_chk(input string name, input int idx, input logic [N-1:0] val, input int len);
        if (runs_val.size() > idx) begin
            chk({name, "_val"}, runs_val[idx], val);
            if (len > 0) chk({name, "_len"}, runs_len[idx], len);
        end else begin
            checks++; errors++;
            $display("FAIL %s: run %0d missing, got %0d runs expected more", name, idx, runs_val.size());
        end
    endtask

    task automatic gap_chk(input string name, input int idx, input int len);
        if (gaps.size() > idx) begin
            chk(name, gaps[idx], len);
        end else begin
            checks++; errors++;
            $display("FAIL %s: gap %0d missing, got %0d gaps", name, idx, gaps.size());
        end
    endtask

    task automatic reset_literals(input string name);
        chk({name, "_sw_en"}, bus.sw_en, 4'b0000);
        chk({name, "_sw_en_n"}, bus.sw_en_n, 4'b1111);
        chk({name, "_busy"}, bus.busy, 1'b0);
        chk({name, "_owner"}, bus.owner, 2'd0);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        repeat (2) tick();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bus.req = '0;
        model_reset();
        clear_log();

        // 1: reset values, then idle with no requests.
        #12;
        reset_literals("rst");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("idle_sw_en", bus.sw_en, 4'b0000);

        // 2: one-cycle request gets exactly MIN_HOLD cycles, then DEAD gap.
        clear_log();
        bus.req = 4'b0100;
        tick();
        bus.req = 4'b0000;
        repeat (10) tick();
        run_chk("short", 0, 4'b0100, 4);

        // 3: from reset, 0101 -> owner 0 for 6, gap 2, owner 2; pointer then 3.
        pulse_reset();
        clear_log();
        bus.req = 4'b0101;
        repeat (6) tick();
        bus.req = 4'b0100;
        repeat (10) tick();
        bus.req = 4'b0000;
        repeat (10) tick();
        run_chk("two0", 0, 4'b0001, 6);
        gap_chk("two_gap", 0, 2);
        run_chk("two1", 1, 4'b0100, 8);
        bus.req = 4'b1111;
        tick();
        chk("ptr3_owner", bus.owner, 2'd3);
        chk("ptr3_sw_en", bus.sw_en, 4'b1000);
        bus.req = 4'b0000;
        repeat (8) tick();

        // 4: fairness timeout evicts owner 1 after exactly MAX_HOLD cycles.
        clear_log();
        bus.req = 4'b0010;
        repeat (2) tick();
        bus.req = 4'b1010;
        repeat (24) tick();
        bus.req = 4'b0000;
        repeat (10) tick();
        run_chk("tmo0", 0, 4'b0010, 16);
        gap_chk("tmo_gap", 0, 2);
        run_chk("tmo1", 1, 4'b1000, 8);

        // 5: asynchronous reset in the middle of ON, then pointer restarts at 0.
        bus.req = 4'b0010;
        repeat (5) tick();
        chk("pre_rst_sw_en", bus.sw_en, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        reset_literals("midrst");
        model_reset();
        repeat (2) tick();
        #1 rst_n = 1'b1;
        clear_log();
        bus.req = 4'b1111;
        tick();
        chk("after_rst_owner", bus.owner, 2'd0);
        chk("after_rst_sw_en", bus.sw_en, 4'b0001);

        // 6: all requesting -> owners 0,1,2,3,0 each MAX_HOLD, 2-cycle gaps.
        repeat (74) tick();
        run_chk("sat0", 0, 4'b0001, 16);
        run_chk("sat1", 1, 4'b0010, 16);
        run_chk("sat2", 2, 4'b0100, 16);
        run_chk("sat3", 3, 4'b1000, 16);
        gap_chk("sat_gap0", 0, 2);
        gap_chk("sat_gap1", 1, 2);
        gap_chk("sat_gap2", 2, 2);
        gap_chk("sat_gap3", 3, 2);
        chk("sat_wrap", bus.sw_en, 4'b0001);
        bus.req = 4'b0000;
        repeat (10) tick();
        chk("final_busy", bus.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/switch_arbiter.md
# switch_arbiter

Break-before-make arbiter for a shared switch-level transmission-gate path. N requesters compete for one shared node. The block grants at most one requester at a time via complementary gate enables (NMOS/PMOS). It enforces a dead time between owners, a minimum on-time and an optional fairness timeout. It sits between the digital requesters and the switch-level gate instances that drive the shared node.

## Interface
- N, default 4: number of requesters / gates (≥2).
- DEAD_CYCLES, default 2: cycles with all gates open between owners (≥1).
- MIN_HOLD, default 4: minimum cycles a granted gate stays closed (≥1).
- MAX_HOLD, default 16: forced-release limit when others wait; 0 disables; if nonzero, MAX_HOLD ≥ MIN_HOLD.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request per requester; held high while the path is wanted.
- sw_en  output  N  NMOS gate enables; at most one bit high; registered.
- sw_en_n  output  N  PMOS gate enables; always bitwise ~sw_en; registered.
- owner  output  $clog2(N)  index of current owner; valid only while sw_en != 0.
- busy  output  1  high in ON or DEAD.

## Operation
- Reset values (asserted asynchronously, no clock needed): sw_en=0, sw_en_n=all ones, owner=0, busy=0, state IDLE, rr pointer=0, counters=0.
- State IDLE:
  - If any req bit is set, pick the winner by round-robin: the first set bit scanning from the pointer upward, wrapping at N-1→0.
  - Then load owner, set sw_en=one-hot(winner), clear hold_cnt, and go to ON.
  - Otherwise stay in IDLE.
- State ON:
  - hold_cnt increments each cycle and saturates at max(MIN_HOLD, MAX_HOLD).
  - hold_cnt is 0 in the first cycle sw_en is high.
  - Release when either condition holds:
    - req[owner]==0 and hold_cnt ≥ MIN_HOLD-1; or
    - MAX_HOLD≠0, hold_cnt == MAX_HOLD-1, and any req bit other than owner is set.
  - On release: sw_en=0, pointer=(owner+1) mod N, dead_cnt=0, go to DEAD.
  - If req[owner] drops before MIN_HOLD is met, the gate stays closed until the MIN_HOLD cycle.
- State DEAD: sw_en stays 0 and dead_cnt increments. At the edge where dead_cnt == DEAD_CYCLES-1:
  - if any req bit is set, arbitrate as in IDLE and go directly to ON;
  - otherwise go to IDLE.
- Break-before-make invariant:
  - no cycle has two sw_en bits high;
  - sw_en is all-zero for exactly DEAD_CYCLES cycles between any two owners;
  - this includes the same requester regaining the path.
- Simultaneous events:
  - A req rising in the same cycle the owner releases is seen at the next arbitration.
  - req[owner] high again during DEAD does not skip the dead time.
- Round-robin: the pointer advances only on release, so a continuously requesting set is served in index order.

## Timing
- Grant latency from IDLE: req sampled high at edge k gives sw_en high after edge k (1-cycle registered).
- Release latency: release condition sampled at edge k gives sw_en=0 after edge k.
- Grant from DEAD: the new owner's gate closes after the edge that ends the DEAD_CYCLES-th all-open cycle.
- On-time bounds per grant:
  - at least MIN_HOLD cycles;
  - exactly MAX_HOLD cycles when the timeout fires;
  - unbounded if MAX_HOLD=0 or there are no competitors.
- Reset mid-ON or mid-DEAD opens all gates immediately (asynchronously). The first grant after rst_n deasserts uses pointer 0.
- Outputs are pure flops; there is no combinational path from req to sw_en.

## Test plan
All scenarios use N=4, DEAD=2, MIN=4, MAX=16.
1. Reset check: hold rst_n low -> sw_en=0000, sw_en_n=1111, busy=0, owner=0; release reset with req=0000 -> outputs unchanged for 10 cycles.
2. Short request: req=0100 for 1 cycle from IDLE -> sw_en=0100 for exactly 4 cycles, then 0000 with busy=1 for 2 cycles, then busy=0.
3. Two requests from reset: req=0101 from IDLE (pointer 0) -> owner 0 granted; drop req[0] after 6 cycles -> sw_en 0001 for 6 cycles, 0000 for 2 cycles, then 0100 with owner=2; after its release the pointer is 3.
4. Fairness timeout: req[1] held permanently, req[3] asserted at cycle 3 of ownership -> sw_en=0010 for exactly 16 cycles, 0000 for 2, then 1000.
5. Reset mid-operation: assert rst_n low mid-ON between clock edges -> sw_en=0000 and sw_en_n=1111 before the next edge; after reset, req=1111 -> owner 0 first.
6. Saturated requesters: req=1111 held -> owners 0,1,2,3,0 in turn, each 16 cycles, separated by 2-cycle all-zero gaps; never more than one sw_en bit high.
